// File: rtl/serial_byte_collector.sv
// Reassembles MSB-first serial bits into WIDTH-bit words and buffers them in a
// DEPTH-entry FIFO that drains through a registered valid/ready output.
module serial_byte_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sin,
    input  logic                     sin_en,
    input  logic                     sync,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word;
    logic             push;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             pop, full, push_ok, drop;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        word    = {acc_q[WIDTH-2:0], sin};
        if (sin_en) begin
            // A sync bit always restarts the word, even where it would have completed one.
            if (sync || state_q == IDLE) begin
                state_d = COLLECT;
                acc_d   = {{(WIDTH-1){1'b0}}, sin};
                cnt_d   = CW'(1);
            end else if (cnt_q == CW'(WIDTH - 1)) begin
                push    = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d   = word;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        pop      = dout_valid & dout_ready;
        full     = (fill_q == FW'(DEPTH));
        push_ok  = push & (~full | pop);
        drop     = push & full & ~pop;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok && !pop) begin
            fill_d = fill_q + FW'(1);
        end else if (pop && !push_ok) begin
            fill_d = fill_q - FW'(1);
        end
        // The word being written lands at the new head only when the FIFO drains to it.
        if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = word;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (fill_q != '0);
    assign bit_cnt    = cnt_q;
    assign fill       = fill_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed bench for serial_byte_collector: vector table plus multi-cycle sequences.
module tb_serial_byte_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       sync = 1'b0;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] bit_cnt;
    logic [2:0] fill;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    serial_byte_collector #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .bit_cnt    (bit_cnt),
        .fill       (fill),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       sin;
        logic       sync;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_dout;
        logic [2:0] e_cnt;
        logic [2:0] e_fill;
        logic       e_ovf;
        logic       chk_dout;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic en, logic s, logic sy, logic rdy,
                                logic ev, logic [7:0] ed, int ec, int ef, logic eo,
                                logic cd);
        vec_t v;
        v.rst = r; v.en = en; v.sin = s; v.sync = sy; v.rdy = rdy;
        v.e_valid = ev; v.e_dout = ed; v.e_cnt = 3'(ec); v.e_fill = 3'(ef);
        v.e_ovf = eo; v.chk_dout = cd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; sin_en = 1'b0; sync = 1'b0; dout_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        for (int i = 7; i >= 0; i--) begin
            sin = w[i]; sin_en = 1'b1;
            tick();
            sin_en = 1'b0;
            repeat (gap) tick();
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] exp_q[$];
        logic [15:0] act_p, exp_p;

        // Vector table: reset, single byte, resync, sync on the would-be last bit.
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        b = 8'h65;
        for (int k = 1; k <= 8; k++)
            vq.push_back(mk(0, 1, b[8-k], 0, 0, k == 8, 8'h65, k % 8, (k == 8) ? 1 : 0, 0, k == 8));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 8'h65, 0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        for (int k = 1; k <= 3; k++)
            vq.push_back(mk(0, 1, 1, 0, 0, 0, 8'h00, k, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 3, 0, 0, 0));
        b = 8'hA5;
        for (int k = 1; k <= 8; k++)
            vq.push_back(mk(0, 1, b[8-k], k == 1, 0, k == 8, 8'hA5, k % 8, (k == 8) ? 1 : 0, 0, k == 8));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        for (int k = 1; k <= 7; k++)
            vq.push_back(mk(0, 1, 1, 0, 0, 0, 8'h00, k, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0));

        foreach (vq[i]) begin
            rst = vq[i].rst; sin_en = vq[i].en; sin = vq[i].sin;
            sync = vq[i].sync; dout_ready = vq[i].rdy;
            tick();
            exp_p = {vq[i].e_valid, vq[i].e_dout, vq[i].e_cnt, vq[i].e_fill, vq[i].e_ovf};
            act_p = {dout_valid, vq[i].chk_dout ? dout : vq[i].e_dout, bit_cnt, fill, overflow};
            check($sformatf("vec[%0d]", i), int'(act_p), int'(exp_p));
        end
        rst = 1'b0; sin_en = 1'b0; sync = 1'b0; dout_ready = 1'b0;

        // Gapped input: bit count must hold through idle cycles.
        do_reset();
        b = 8'h65;
        for (int i = 7; i >= 0; i--) begin
            sin = b[i]; sin_en = 1'b1;
            tick();
            sin_en = 1'b0;
            repeat (2) tick();
            if (i == 5) check("gap_cnt_hold", int'(bit_cnt), 3);
        end
        check("gap_dout", int'(dout), 8'h65);
        check("gap_valid", int'(dout_valid), 1);
        check("gap_fill", int'(fill), 1);

        // Fill past capacity with no consumer.
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            send_word(8'(w), 0);
            if (w == 4) begin
                check("ovf_fill4", int'(fill), 4);
                check("ovf_not_yet", int'(overflow), 0);
            end
        end
        check("ovf_fill_full", int'(fill), 4);
        check("ovf_set", int'(overflow), 1);
        dout_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            check($sformatf("ovf_pop%0d", w), int'(dout), w);
            tick();
        end
        dout_ready = 1'b0;
        check("ovf_drained", int'(dout_valid), 0);
        check("ovf_sticky", int'(overflow), 1);

        // Full FIFO: completing a word on the same edge as a pop must not drop.
        do_reset();
        check("rst_clears_ovf", int'(overflow), 0);
        for (int w = 0; w < 4; w++) send_word(8'h10 + 8'(w), 0);
        b = 8'h14;
        for (int i = 7; i >= 0; i--) begin
            sin = b[i]; sin_en = 1'b1;
            dout_ready = (i == 0);
            tick();
        end
        sin_en = 1'b0; dout_ready = 1'b0;
        check("full_pp_fill", int'(fill), 4);
        check("full_pp_ovf", int'(overflow), 0);
        check("full_pp_hold", int'(dout), 8'h11);
        tick();
        check("full_pp_hold2", int'(dout), 8'h11);
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14};
        dout_ready = 1'b1;
        foreach (exp_q[i]) begin
            check($sformatf("full_pp_pop%0d", i), int'(dout), int'(exp_q[i]));
            tick();
        end
        dout_ready = 1'b0;
        check("full_pp_empty", int'(dout_valid), 0);

        // Reset with words buffered and a partial word in flight.
        do_reset();
        send_word(8'hAA, 0);
        send_word(8'hBB, 0);
        b = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            sin = b[i]; sin_en = 1'b1;
            tick();
        end
        sin_en = 1'b0;
        check("mid_cnt", int'(bit_cnt), 5);
        check("mid_fill", int'(fill), 2);
        do_reset();
        check("mid_rst", int'({dout_valid, fill, bit_cnt, overflow, dout}), 0);
        send_word(8'h3C, 0);
        check("mid_dout", int'(dout), 8'h3C);
        check("mid_valid", int'(dout_valid), 1);
        check("mid_fill1", int'(fill), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
